// File: rtl/ngc_fifo_unpacker_pkg.sv
// Shared types and sizing helpers for the FIFO word unpacker.
// Imported by the unpacker top.
package ngc_fifo_unpacker_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } unpack_state_t;

  function automatic int unpack_ratio(
    input int dw,
    input int ow
  );
    return dw / ow;
  endfunction

  function automatic int unpack_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/ngc_fifo_unpacker.sv
// Pops wide FIFO words and emits them as narrow valid/ready beats,
// with a one-word prefetch buffer covering the FIFO read latency.
module ngc_fifo_unpacker
  import ngc_fifo_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int RATIO = unpack_ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int CW    = unpack_cnt_w(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  if (RATIO < 2 || RATIO * OUT_WIDTH != DATA_WIDTH) begin : g_bad_ratio
    $error("DATA_WIDTH/OUT_WIDTH must be an integer >= 2");
  end

  unpack_state_t         state_q;
  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] nxt_q;
  logic [CW-1:0]         cnt_q;
  logic                  pending_q;
  logic                  nxt_valid_q;

  logic                  hs;
  logic                  frees;
  int                    sel;
  logic [DATA_WIDTH-1:0] shifted;

  assign fifo_pop = !rst && !fifo_empty
                 && !pending_q && !nxt_valid_q;

  assign m_valid = (state_q == RUN);
  assign m_last  = (cnt_q == LAST);
  assign busy    = pending_q | nxt_valid_q | m_valid;

  assign hs    = m_valid && m_ready;
  assign frees = (state_q == IDLE) || (hs && m_last);

  always_comb begin
    sel     = 0;
    shifted = '0;
    if (MSB_FIRST) begin
      sel = RATIO - 1 - int'(cnt_q);
    end else begin
      sel = int'(cnt_q);
    end
    shifted = sr_q >> (sel * OUT_WIDTH);
  end

  assign m_data = shifted[OUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      nxt_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      nxt_valid_q <= 1'b0;
    end else begin
      pending_q <= fifo_pop;
      if (frees) begin
        if (nxt_valid_q) begin
          sr_q    <= nxt_q;
          cnt_q   <= '0;
          state_q <= RUN;
          if (pending_q) begin
            nxt_q <= fifo_dout;
          end else begin
            nxt_valid_q <= 1'b0;
          end
        end else if (pending_q) begin
          // bypass: word arrives straight into the active register
          sr_q    <= fifo_dout;
          cnt_q   <= '0;
          state_q <= RUN;
        end else begin
          state_q <= IDLE;
          if (hs) begin
            cnt_q <= '0;
          end
        end
      end else begin
        if (hs) begin
          cnt_q <= cnt_q + CW'(1);
        end
        if (pending_q) begin
          nxt_q       <= fifo_dout;
          nxt_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule
